// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver state type, parity modes and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Parity bit a transmitter sends for this data; unused upper bits must be zero.
    function automatic logic calc_parity(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - line synchronizer, bit timing and frame FSM of the UART receiver
import uart_pkg::*;

module uart_rx_core #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic                 byte_valid,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 byte_perr,
    output logic                 start_ok,
    output logic                 frame_err,
    output logic                 line_idle
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic                 sync1, sync2;
    logic [1:0]           sync_fill;
    uart_rx_state_t       state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err;

    // sync_fill keeps WAIT_HIGH from trusting the flops' reset value of 1 as a real idle line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            sync1     <= uart_rx;
            sync2     <= sync1;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign line_idle = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_HIGH;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_err    <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_perr  <= 1'b0;
            start_ok   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            start_ok   <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                WAIT_HIGH: if (sync_fill[1] && sync2) state <= IDLE;
                IDLE: begin
                    if (!sync2) begin
                        state   <= START;
                        cnt     <= '0;
                        par_err <= 1'b0;
                    end
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (sync2) begin
                            state <= IDLE;
                        end else begin
                            state    <= DATA;
                            bit_idx  <= '0;
                            start_ok <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        shift <= {sync2, shift[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) state <= (PARITY_EN != 0) ? PARITY : STOP;
                        else                     bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt     <= '0;
                        par_err <= (sync2 != calc_parity(32'(shift), PAR_MODE));
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (sync2) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                            byte_perr  <= par_err;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_axis.sv
// rtl/uart_rx_axis.sv - UART receiver with pend/output staging that rebuilds packets from line idle time
import uart_pkg::*;

module uart_rx_axis #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int IDLE_BITS    = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] m_axis_data,
    output logic                 m_axis_valid,
    input  logic                 m_axis_ready,
    output logic                 m_axis_last,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
    localparam int IW = $clog2(IDLE_LIMIT + 2);

    logic                 byte_valid, byte_perr, start_ok, core_ferr, line_idle;
    logic [DATA_BITS-1:0] byte_data;
    logic [IW-1:0]        idle_cnt;
    logic                 idle_hit, pend_move, pend_take;
    logic                 pend_full, pend_resolved, pend_last, pend_perr;
    logic [DATA_BITS-1:0] pend_data;

    uart_rx_core #(
        .DATA_BITS   (DATA_BITS),
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .PARITY_EN   (PARITY_EN),
        .PARITY_ODD  (PARITY_ODD)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_perr (byte_perr),
        .start_ok  (start_ok),
        .frame_err (core_ferr),
        .line_idle (line_idle)
    );

    // Saturates one past the limit so the timeout fires exactly once per idle stretch
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                idle_cnt <= '0;
        else if (!line_idle)                    idle_cnt <= '0;
        else if (idle_cnt <= IW'(IDLE_LIMIT))   idle_cnt <= idle_cnt + 1'b1;
    end

    assign idle_hit  = line_idle && (idle_cnt == IW'(IDLE_LIMIT));
    assign pend_move = pend_full && pend_resolved && (!m_axis_valid || m_axis_ready);
    assign pend_take = byte_valid && (!pend_full || pend_move);
    assign overrun   = byte_valid && !pend_take;
    assign frame_err = core_ferr;

    // Whenever the successor byte is lost (timeout, bad frame, overrun) the pend byte ends its packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_full     <= 1'b0;
            pend_resolved <= 1'b0;
            pend_last     <= 1'b0;
            pend_perr     <= 1'b0;
            pend_data     <= '0;
        end else if (pend_take) begin
            pend_full     <= 1'b1;
            pend_resolved <= 1'b0;
            pend_last     <= 1'b0;
            pend_perr     <= byte_perr;
            pend_data     <= byte_data;
        end else begin
            if (pend_move) pend_full <= 1'b0;
            if (pend_full) begin
                if (start_ok) pend_resolved <= 1'b1;
                if (idle_hit || core_ferr || overrun) begin
                    pend_resolved <= 1'b1;
                    pend_last     <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
            parity_err   <= 1'b0;
        end else if (pend_move) begin
            m_axis_valid <= 1'b1;
            m_axis_data  <= pend_data;
            m_axis_last  <= pend_last;
            parity_err   <= pend_perr;
        end else if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_axis.md
# uart_rx_axis

UART receiver that turns the serial line driven by the design's UART transmitter back into an AXI-Stream byte stream; it is the downstream counterpart of the AXI-Stream-to-UART transmit path. It oversamples the line and checks parity and stop bit. Packet boundaries are recovered from line idle time, so a frame burst sent by the transmitter comes back out as one AXI-Stream packet with `m_axis_last` on its final byte.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `CLKS_PER_BIT`, default 87: clock cycles per bit. Must be ≥ 4.
- `PARITY_EN`, default 1: parity bit present when 1.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd.
- `IDLE_BITS`, default 20: idle bit-times after the stop-bit sample that close a packet.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `uart_rx` in 1: serial line, asynchronous, idle high.
- `m_axis_data` out DATA_BITS: received byte.
- `m_axis_valid` out 1: beat valid.
- `m_axis_ready` in 1: downstream ready.
- `m_axis_last` out 1: final byte of the packet.
- `parity_err` out 1: sideband, qualified by `m_axis_valid`.
- `frame_err` out 1: one-cycle pulse on a bad stop bit.
- `overrun` out 1: one-cycle pulse when a completed byte is dropped.

## Operation
- `uart_rx` passes through a 2-flop synchronizer; both flops reset to 1.
- FSM states: WAIT_HIGH, IDLE, START, DATA, PARITY, STOP.
- After reset the FSM is in WAIT_HIGH. It goes to IDLE once the synchronized line reads 1.
- IDLE: a synchronized 0 moves the FSM to START and clears the bit counter.
- START: at count (CLKS_PER_BIT-1)/2 the line is resampled.
  - If it reads 1, the event is a glitch and the FSM returns to IDLE.
  - If it reads 0, the start bit is verified and the FSM goes to DATA.
- DATA: samples every CLKS_PER_BIT cycles, DATA_BITS samples, shifted in LSB first.
- After DATA the FSM goes to PARITY if PARITY_EN, otherwise to STOP.
- PARITY: one sample. An error is flagged when XOR(data, parity bit) ≠ PARITY_ODD.
- STOP: one sample.
  - If the sample is 1, the byte is complete and the FSM goes to IDLE.
  - If the sample is 0, `frame_err` pulses, the byte is discarded and the FSM goes to WAIT_HIGH.
- Staging uses two slots: a pend slot and an output slot. Each slot holds data, parity flag and last flag. The pend slot also holds a resolved bit.
- A complete byte enters pend unresolved.
  - If pend is already occupied, the new byte is dropped and `overrun` pulses.
- Resolution of the pend byte:
  - Next start bit verified: resolved with last = 0.
  - Idle counter reaching IDLE_BITS*CLKS_PER_BIT: resolved with last = 1.
  - A frame error: resolved with last = 1.
- Idle counter: counts cycles since the last stop-bit sample while the FSM is in IDLE. It is cleared on entry to START.
- A resolved pend byte moves to the output slot when the slot is empty, or when the slot is being accepted in the same cycle (valid && ready).
- Handshake: `m_axis_valid` stays high with data stable until `m_axis_ready`. No combinational path exists from `m_axis_ready` to `m_axis_valid`.

## Timing
- Reset values:
  - `m_axis_valid`, `m_axis_last`, `parity_err`, `frame_err`, `overrun` = 0.
  - `m_axis_data` = 0.
  - Both slots empty.
- Asserting `rst` mid-frame loses the partial byte and both slots.
- Sample points fall at cycles (CLKS_PER_BIT-1)/2 + k·CLKS_PER_BIT after the falling edge is seen. The synchronizer adds 2 cycles of line delay.
- Non-last byte: `m_axis_valid` rises 2 cycles after the next start bit is verified, with the output slot empty.
- Last byte: `m_axis_valid` rises 2 cycles after idle timeout.
- Accepted beat plus resolved pend in the same cycle: the next beat is valid the following cycle, giving back-to-back beats.
- `frame_err` and `overrun` pulse in the cycle after the offending stop sample.

## Structure
- Package `uart_pkg` holds:
  - the `uart_rx_state_t` enum;
  - the parity-mode constants;
  - the function `calc_parity(data, odd)`, shared with the transmitter.
- Sub-module `uart_rx_core` contains the synchronizer, baud counter, FSM and shift register. It emits `byte_valid`, `byte_data`, `byte_perr`, `start_ok`, `frame_err` and `line_idle`.
- Top level `uart_rx_axis` contains the pend and output slots, the idle counter, last resolution and overrun.

## Test plan
Bench uses CLKS_PER_BIT = 16 and IDLE_BITS = 20.
- Single frame 0xA5 with even parity bit 0, `m_axis_ready` = 1 → one beat: data 0xA5, last 1, `parity_err` 0, valid 322 cycles after the stop sample.
- Frames 0x01, 0x02, 0x03 back-to-back → three beats with last = 0, 0, 1 and no `overrun`.
- Frame 0x0F with parity bit 1 (even mode) → beat 0x0F with `parity_err` = 1. A following good frame gives `parity_err` = 0.
- Frame 0x55 with stop bit 0 → `frame_err` pulses once, no beat. A subsequent 0x33 is received normally after the line returns high.
- `m_axis_ready` = 0 during frames 0x11, 0x22, 0x33 back-to-back → `overrun` pulses at the 0x33 stop sample. Releasing ready then yields 0x11 (last 0) and 0x22 (last 1).
- 4-cycle low glitch on `uart_rx` → no beat and no error. `rst` pulsed mid-DATA with the line held low → all outputs 0 and no frame until the line goes high then low.
